// File: rtl/colormapper_pipe.sv
// colormapper_pipe: two-stage valid/ready mapper from iteration counts to RGB.
// S1 captures per-beat config, gradient products and palette index; S2 resolves the colour.
module colormapper_pipe #(
  parameter int ITER_W = 8,
  parameter int PAL_DEPTH = 16,
  localparam int PAL_AW = $clog2(PAL_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ITER_W-1:0] in_x,
  input  logic [7:0]        in_y,
  input  logic              in_sof,
  input  logic              in_eol,
  input  logic [2:0]        mode,
  input  logic [23:0]       color0,
  input  logic [23:0]       color1,
  input  logic              cycle_en,
  input  logic              pal_we,
  input  logic [PAL_AW-1:0] pal_addr,
  input  logic [23:0]       pal_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b,
  output logic              out_sof,
  output logic              out_eol
);
  logic                   w_en, w_acc;
  logic [7:0]             w_t;
  logic [0:2][7:0]        w_c0, w_c1, w_diff, w_grad;
  logic [0:2][15:0]       w_prod;
  logic [0:2]             w_dn;
  logic [23:0]            w_rgb;
  logic                   r_v1, r_sof1, r_eol1;
  logic [2:0]             r_mode;
  logic [7:0]             r_t, r_y;
  logic [PAL_AW-1:0]      r_idx, r_off;
  logic [0:2][7:0]        r_c0;
  logic [0:2][15:0]       r_prod;
  logic [0:2]             r_dn;
  logic [23:0]            r_pal [PAL_DEPTH];
  assign w_en = ~out_valid | out_ready;
  assign in_ready = w_en;
  assign w_acc = in_valid & w_en;
  assign w_t = in_x[ITER_W-1 -: 8];
  assign w_c0 = color0;
  assign w_c1 = color1;
  // Gradient works on the absolute channel difference so the product never goes negative.
  always_comb begin
    w_dn = '0;
    w_diff = '0;
    w_prod = '0;
    for (int k = 0; k < 3; k++) begin
      w_dn[k] = w_c1[k] < w_c0[k];
      w_diff[k] = w_dn[k] ? w_c0[k] - w_c1[k] : w_c1[k] - w_c0[k];
      w_prod[k] = {8'h00, w_diff[k]} * {8'h00, w_t};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_sof1 <= 1'b0;
      r_eol1 <= 1'b0;
      r_mode <= '0;
      r_t <= '0;
      r_y <= '0;
      r_idx <= '0;
      r_c0 <= '0;
      r_prod <= '0;
      r_dn <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_sof1 <= in_sof;
      r_eol1 <= in_eol;
      r_mode <= mode;
      r_t <= w_t;
      r_y <= in_y;
      r_idx <= in_x[PAL_AW-1:0] + r_off;
      r_c0 <= w_c0;
      r_prod <= w_prod;
      r_dn <= w_dn;
    end
  end
  always_ff @(posedge clk) begin
    if (reset)
      r_off <= '0;
    else if (w_acc && in_sof && cycle_en)
      r_off <= r_off + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < PAL_DEPTH; k++) r_pal[k] <= '0;
    end else if (pal_we) begin
      r_pal[pal_addr] <= pal_wdata;
    end
  end
  always_comb begin
    w_grad = '0;
    for (int k = 0; k < 3; k++)
      w_grad[k] = r_dn[k] ? r_c0[k] - r_prod[k][15:8] : r_c0[k] + r_prod[k][15:8];
  end
  assign w_rgb = (r_mode == 3'd0) ? {8'h00, r_y, r_t} :
                 (r_mode == 3'd1) ? {3{r_t}} :
                 (r_mode == 3'd2) ? w_grad :
                 (r_mode == 3'd3) ? r_pal[r_idx] :
                 (r_mode == 3'd4) ? 24'h000000 : {8'h00, r_t, r_y};
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      {out_r, out_g, out_b} <= '0;
      out_sof <= 1'b0;
      out_eol <= 1'b0;
    end else if (w_en) begin
      out_valid <= r_v1;
      {out_r, out_g, out_b} <= w_rgb;
      out_sof <= r_sof1;
      out_eol <= r_eol1;
    end
  end
endmodule
